// File: rtl/vga_timing_gen.sv
// Raster timing generator on the pixel clock: syncs, display enable, pixel and look-ahead
// fetch coordinates, line/frame strobes and a wrapping frame counter. All outputs registered.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned LEAD     = 1
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  output logic       h_sync,
  output logic       v_sync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [9:0] fetch_x,
  output logic [9:0] fetch_y,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || LEAD >= H_TOTAL) begin : g_bad_cfg
    $error("vga_timing_gen: illegal geometry or LEAD");
  end

  localparam logic [9:0]  H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_TOT_W  = 11'(H_TOTAL);
  localparam logic [10:0] LEAD_W   = 11'(LEAD);
  localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        POL      = (SYNC_POL != 0);
  // Look-ahead of the reset point (H_MAX, V_MAX).
  localparam logic [9:0]  RST_FX   = (LEAD == 0) ? 10'(H_TOTAL - 1) : 10'(LEAD - 1);
  localparam logic [9:0]  RST_FY   = (LEAD == 0) ? 10'(V_TOTAL - 1) : 10'd0;

  logic [9:0]  x_q, y_q, x_d, y_d, fx_q, fy_q, fx_d, fy_d;
  logic [10:0] fsum;
  logic        hs_q, vs_q, de_q, ls_q, fs_q, first_q;
  logic        hs_d, vs_d, de_d;
  logic [7:0]  fc_q;

  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == H_MAX) begin
      x_d = 10'd0;
      y_d = (y_q == V_MAX) ? 10'd0 : y_q + 10'd1;
    end

    fsum = {1'b0, x_d} + LEAD_W;
    fx_d = fsum[9:0];
    fy_d = y_d;
    if (fsum >= H_TOT_W) begin
      fx_d = 10'(fsum - H_TOT_W);
      fy_d = (y_d == V_MAX) ? 10'd0 : y_d + 10'd1;
    end

    hs_d = ({1'b0, x_d} >= HS_BEG && {1'b0, x_d} < HS_END) ? POL : ~POL;
    vs_d = ({1'b0, y_d} >= VS_BEG && {1'b0, y_d} < VS_END) ? POL : ~POL;
    de_d = ({1'b0, x_d} < H_ACT_W) && ({1'b0, y_d} < V_ACT_W);
  end

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      x_q     <= H_MAX;
      y_q     <= V_MAX;
      fx_q    <= RST_FX;
      fy_q    <= RST_FY;
      hs_q    <= ~POL;
      vs_q    <= ~POL;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= 8'd0;
      first_q <= 1'b1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      ls_q    <= (x_d == 10'd0);
      fs_q    <= (x_d == 10'd0) && (y_d == 10'd0);
      first_q <= 1'b0;
      // The restart frame after reset keeps count 0; later frames advance it.
      if (x_d == 10'd0 && y_d == 10'd0 && !first_q) fc_q <= fc_q + 8'd1;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign fetch_x     = fx_q;
  assign fetch_y     = fy_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default geometry (LEAD 1 and 8) plus a tiny geometry
// (SYNC_POL 1, LEAD at its maximum) used for frame-level and frame counter wrap checks.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] fx;
    logic [9:0] fy;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_def = 1'b0;
  logic rst_sml = 1'b0;

  obs_t o_def, o_l8, o_sml;

  vga_timing_gen u_def (
    .vga_clk(clk), .rst_n(rst_def), .h_sync(o_def.hs), .v_sync(o_def.vs), .de(o_def.de),
    .x(o_def.x), .y(o_def.y), .fetch_x(o_def.fx), .fetch_y(o_def.fy),
    .line_start(o_def.ls), .frame_start(o_def.fs), .frame_cnt(o_def.fc)
  );

  vga_timing_gen #(.LEAD(8)) u_l8 (
    .vga_clk(clk), .rst_n(rst_def), .h_sync(o_l8.hs), .v_sync(o_l8.vs), .de(o_l8.de),
    .x(o_l8.x), .y(o_l8.y), .fetch_x(o_l8.fx), .fetch_y(o_l8.fy),
    .line_start(o_l8.ls), .frame_start(o_l8.fs), .frame_cnt(o_l8.fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1), .LEAD(14)
  ) u_sml (
    .vga_clk(clk), .rst_n(rst_sml), .h_sync(o_sml.hs), .v_sync(o_sml.vs), .de(o_sml.de),
    .x(o_sml.x), .y(o_sml.y), .fetch_x(o_sml.fx), .fetch_y(o_sml.fy),
    .line_start(o_sml.ls), .frame_start(o_sml.fs), .frame_cnt(o_sml.fc)
  );

  int checks = 0;
  int errors = 0;
  obs_t q_def[$], q_l8[$], q_sml[$];

  // Reference raster state per reset domain.
  int dx = 0, dy = 0, dfc = 0;
  bit dfirst = 1'b1;
  int sx = 0, sy = 0, sfc = 0;
  bit sfirst = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic adv(input logic rst, input int ht, input int vt,
                     inout int cx, inout int cy, inout int cfc, inout bit first);
    if (!rst) begin
      cx = ht - 1; cy = vt - 1; cfc = 0; first = 1'b1;
    end else begin
      if (cx == ht - 1) begin
        cx = 0;
        cy = (cy == vt - 1) ? 0 : cy + 1;
      end else begin
        cx = cx + 1;
      end
      if (cx == 0 && cy == 0) begin
        if (first) first = 1'b0;
        else cfc = (cfc + 1) % 256;
      end
    end
  endtask

  function automatic obs_t model(int cx, int cy, int cfc, int ha, int hf, int hw, int ht,
                                 int va, int vf, int vw, int vt, int lead, bit pol);
    obs_t o;
    int t;
    o.hs = (cx >= ha + hf && cx < ha + hf + hw) ? pol : !pol;
    o.vs = (cy >= va + vf && cy < va + vf + vw) ? pol : !pol;
    o.de = (cx < ha) && (cy < va);
    o.x  = 10'(cx);
    o.y  = 10'(cy);
    t = cx + lead;
    if (t >= ht) begin
      o.fx = 10'(t - ht);
      o.fy = 10'((cy + 1) % vt);
    end else begin
      o.fx = 10'(t);
      o.fy = 10'(cy);
    end
    o.ls = (cx == 0);
    o.fs = (cx == 0) && (cy == 0);
    o.fc = 8'(cfc);
    return o;
  endfunction

  // One clock: predict, push, clock, pop and compare every DUT.
  task automatic step();
    adv(rst_def, 800, 525, dx, dy, dfc, dfirst);
    q_def.push_back(model(dx, dy, dfc, 640, 16, 96, 800, 480, 10, 2, 525, 1, 1'b0));
    q_l8.push_back(model(dx, dy, dfc, 640, 16, 96, 800, 480, 10, 2, 525, 8, 1'b0));
    adv(rst_sml, 15, 11, sx, sy, sfc, sfirst);
    q_sml.push_back(model(sx, sy, sfc, 8, 2, 3, 15, 6, 1, 2, 11, 14, 1'b1));
    @(posedge clk);
    #1;
    check("def_cycle", 64'(o_def), 64'(q_def.pop_front()));
    check("l8_cycle", 64'(o_l8), 64'(q_l8.pop_front()));
    check("sml_cycle", 64'(o_sml), 64'(q_sml.pop_front()));
  endtask

  initial begin
    int n, de_cnt, hs_cnt, ls_cnt, vs_cnt, fs_cnt;

    // Reset held for three clocks.
    repeat (3) step();
    check("rst_x", 64'(o_def.x), 64'd799);
    check("rst_y", 64'(o_def.y), 64'd524);
    check("rst_de", 64'(o_def.de), 64'd0);
    check("rst_syncs", 64'({o_def.hs, o_def.vs}), 64'd3);
    check("rst_strobes", 64'({o_def.ls, o_def.fs}), 64'd0);
    check("rst_fetch_l1", 64'({o_def.fx, o_def.fy}), 64'({10'd0, 10'd0}));
    check("rst_fetch_l8", 64'({o_l8.fx, o_l8.fy}), 64'({10'd7, 10'd0}));
    check("rst_sml_syncs", 64'({o_sml.hs, o_sml.vs}), 64'd0);
    check("rst_sml_fetch", 64'({o_sml.fx, o_sml.fy}), 64'({10'd13, 10'd0}));

    rst_def = 1'b1;
    rst_sml = 1'b1;
    step();
    check("rel_xy", 64'({o_def.x, o_def.y}), 64'd0);
    check("rel_de_fs", 64'({o_def.de, o_def.fs, o_def.ls}), 64'd7);
    check("rel_fc", 64'(o_def.fc), 64'd0);

    // One full line of default geometry.
    de_cnt = 0; hs_cnt = 0; ls_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      de_cnt += int'(o_def.de);
      hs_cnt += int'(!o_def.hs);
      ls_cnt += int'(o_def.ls);
      step();
    end
    check("line_de_count", 64'(de_cnt), 64'd640);
    check("line_hsync_count", 64'(hs_cnt), 64'd96);
    check("line_start_count", 64'(ls_cnt), 64'd1);
    check("line_period", 64'({o_def.ls, o_def.x, o_def.y}), 64'({1'b1, 10'd0, 10'd1}));

    // LEAD=1 fetch wrap at the end of line 5.
    n = 0;
    while (!(o_def.x == 10'd798 && o_def.y == 10'd5) && n < 5000) begin step(); n++; end
    check("reach_798_5", 64'(n < 5000), 64'd1);
    check("fetch_798_5", 64'({o_def.fx, o_def.fy}), 64'({10'd799, 10'd5}));
    step();
    check("fetch_799_5", 64'({o_def.fx, o_def.fy}), 64'({10'd0, 10'd6}));

    // LEAD=8 wrap at x=795.
    n = 0;
    while (!(o_l8.x == 10'd795) && n < 1000) begin step(); n++; end
    check("reach_795", 64'(n < 1000), 64'd1);
    check("fetch_l8_795", 64'({o_l8.fx, o_l8.fy}), 64'({10'd3, o_l8.y + 10'd1}));

    // Mid-frame reset on the small geometry.
    n = 0;
    while (!(o_sml.x == 10'd5 && o_sml.y == 10'd3) && n < 400) begin step(); n++; end
    check("reach_sml_5_3", 64'(n < 400), 64'd1);
    rst_sml = 1'b0;
    step();
    check("midrst_xy", 64'({o_sml.x, o_sml.y}), 64'({10'd14, 10'd10}));
    rst_sml = 1'b1;
    step();
    check("midrst_restart", 64'({o_sml.x, o_sml.y, o_sml.fs, o_sml.fc}),
          64'({10'd0, 10'd0, 1'b1, 8'd0}));

    // One full small frame: period, vsync width, active area.
    de_cnt = 0; vs_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 165; i++) begin
      de_cnt += int'(o_sml.de);
      vs_cnt += int'(o_sml.vs);
      fs_cnt += int'(o_sml.fs);
      step();
    end
    check("frame_de_count", 64'(de_cnt), 64'd48);
    check("frame_vsync_count", 64'(vs_cnt), 64'd30);
    check("frame_fs_count", 64'(fs_cnt), 64'd1);
    check("frame_period", 64'({o_sml.fs, o_sml.fc}), 64'({1'b1, 8'd1}));

    // Frame counter wrap: frame 255 then back to 0.
    repeat (254 * 165) step();
    check("fc_255_start", 64'({o_sml.fs, o_sml.fc}), 64'({1'b1, 8'd255}));
    repeat (164) step();
    check("fc_255_end", 64'({o_sml.fs, o_sml.fc}), 64'({1'b0, 8'd255}));
    step();
    check("fc_wrap", 64'({o_sml.fs, o_sml.fc}), 64'({1'b1, 8'd0}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
